// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_if
// Description : Handshake and status bundle for sync_fifo. The producer and
//               consumer side (testbench or upstream/downstream stage) uses
//               the master modport. The FIFO itself uses the slave modport.
//
//   Signals (direction as seen from the FIFO / slave side):
//     i_wr_req     in   1         write request
//     i_wr_data    in   DSIZE     write data
//     i_rd_req     in   1         read request (pop / acknowledge in FWFT)
//     o_rd_data    out  DSIZE     read data
//     o_rd_valid   out  1         o_rd_data holds a valid word
//     o_empty      out  1         occupancy == 0
//     o_full       out  1         occupancy == 2^ASIZE
//     o_afull      out  1         occupancy >= AFULL_TH
//     o_aempty     out  1         occupancy <= AEMPTY_TH
//     o_count      out  ASIZE+1   occupancy, 0..2^ASIZE
//     o_overflow   out  1         one-cycle pulse: write rejected
//     o_underflow  out  1         one-cycle pulse: read rejected
//
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
);
    logic             i_wr_req;
    logic [DSIZE-1:0] i_wr_data;
    logic             i_rd_req;
    logic [DSIZE-1:0] o_rd_data;
    logic             o_rd_valid;
    logic             o_empty;
    logic             o_full;
    logic             o_afull;
    logic             o_aempty;
    logic [ASIZE:0]   o_count;
    logic             o_overflow;
    logic             o_underflow;

    // Producer / consumer side
    modport master (
        output i_wr_req,
        output i_wr_data,
        output i_rd_req,
        input  o_rd_data,
        input  o_rd_valid,
        input  o_empty,
        input  o_full,
        input  o_afull,
        input  o_aempty,
        input  o_count,
        input  o_overflow,
        input  o_underflow
    );

    // FIFO side
    modport slave (
        input  i_wr_req,
        input  i_wr_data,
        input  i_rd_req,
        output o_rd_data,
        output o_rd_valid,
        output o_empty,
        output o_full,
        output o_afull,
        output o_aempty,
        output o_count,
        output o_overflow,
        output o_underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock parametrised FIFO with read handshake, full /
//               almost-full / empty / almost-empty flags, an occupancy count,
//               and registered overflow/underflow error pulses.
//
//   Parameters:
//     DSIZE      data word width in bits (>= 1)
//     ASIZE      address width, depth = 2^ASIZE words (>= 1)
//     AFULL_TH   o_afull when occupancy >= AFULL_TH (1..2^ASIZE)
//     AEMPTY_TH  o_aempty when occupancy <= AEMPTY_TH (0..2^ASIZE-1)
//
//   Ports:
//     i_clk      in   clock, all logic on rising edge
//     i_rst      in   synchronous active-high reset
//     bus        sync_fifo_if.slave (write/read handshake, data, status)
//
//   Build option:
//     SYNC_FIFO_FWFT_EN  when defined, first-word-fall-through read mode:
//                        o_rd_data shows the head word combinationally,
//                        o_rd_valid = !o_empty, i_rd_req acknowledges it.
//                        When undefined, standard mode with 1-cycle read
//                        latency and a registered o_rd_data.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = (1 << ASIZE) - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    sync_fifo_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants, all sized to the count width so comparisons are width-exact
    // ------------------------------------------------------------------------
    localparam int             c_depth     = 1 << ASIZE;
    localparam logic [ASIZE:0] c_one       = (ASIZE+1)'(1);
    localparam logic [ASIZE:0] c_full_cnt  = (ASIZE+1)'(c_depth);
    localparam logic [ASIZE:0] c_afull_th  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] c_aempty_th = (ASIZE+1)'(AEMPTY_TH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DSIZE-1:0] r_mem [0:c_depth-1];

    // Pointers carry one extra MSB so they wrap modulo 2^(ASIZE+1); only the
    // low ASIZE bits address the RAM.
    logic [ASIZE:0]   r_wr_ptr;
    logic [ASIZE:0]   r_rd_ptr;

    logic [ASIZE:0]   r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_afull;
    logic             r_aempty;
    logic             r_overflow;
    logic             r_underflow;

    // ------------------------------------------------------------------------
    // Accept decisions. They look only at the registered flags, so a full
    // FIFO rejects a write even when a read is popping in the same cycle, and
    // an empty FIFO rejects a read even when a write lands in the same cycle.
    // ------------------------------------------------------------------------
    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [ASIZE-1:0] w_wr_addr;
    logic [ASIZE-1:0] w_rd_addr;
    logic [ASIZE:0]   w_count_nxt;

    assign w_wr_accept = bus.i_wr_req && !r_full;
    assign w_rd_accept = bus.i_rd_req && !r_empty;
    assign w_wr_addr   = r_wr_ptr[ASIZE-1:0];
    assign w_rd_addr   = r_rd_ptr[ASIZE-1:0];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage. Contents are never cleared; reset only moves the pointers,
    // which is enough to discard everything. Writes are blocked during reset
    // so reset keeps priority over a concurrent request.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr_accept) begin
            r_mem[w_wr_addr] <= bus.i_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy and flags. Every flag is derived from the same next
    // count value, so count and flags are mutually consistent every cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == '0);
            r_full      <= (w_count_nxt == c_full_cnt);
            r_afull     <= (w_count_nxt >= c_afull_th);
            r_aempty    <= (w_count_nxt <= c_aempty_th);
            r_overflow  <= bus.i_wr_req && r_full;
            r_underflow <= bus.i_rd_req && r_empty;
        end
    end

    // ------------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented straight from the RAM. A word written at an
    // edge is therefore visible right after that edge; the value shown while
    // empty is meaningless and qualified off by o_rd_valid.
    assign bus.o_rd_data  = r_mem[w_rd_addr];
    assign bus.o_rd_valid = !r_empty;
`else
    logic [DSIZE-1:0] r_rd_data;
    logic             r_rd_valid;

    // One-cycle read latency: the head word is captured on the accepting
    // edge and held until the next accepted read. A rejected read leaves the
    // data untouched and drops valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_rd_valid = r_rd_valid;
`endif

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign bus.o_count     = r_count;
    assign bus.o_empty     = r_empty;
    assign bus.o_full      = r_full;
    assign bus.o_afull     = r_afull;
    assign bus.o_aempty    = r_aempty;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo (standard read mode,
//               DSIZE=32, ASIZE=4, default thresholds AFULL_TH=14,
//               AEMPTY_TH=2). A reference model tracks occupancy and a
//               scoreboard queue holds written words until they are read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_dsize = 32;
    localparam int c_asize = 4;
    localparam int c_depth = 16;
    localparam int c_afull = 14;
    localparam int c_aemp  = 2;

    logic clk;
    logic rst;

    sync_fifo_if #(.DSIZE(c_dsize), .ASIZE(c_asize)) bus ();

    sync_fifo #(
        .DSIZE    (c_dsize),
        .ASIZE    (c_asize),
        .AFULL_TH (c_afull),
        .AEMPTY_TH(c_aemp)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] sb_q [$];
    int          m_count;
    logic [31:0] m_last_data;

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        rd;
        logic [4:0]  exp_count;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus (called #1 after a rising edge), step over
    // the next edge and compare every output against the model.
    task automatic cycle(input logic wr, input logic [31:0] d, input logic rd);
        logic wr_acc;
        logic rd_acc;
        logic [31:0] exp_d;
        bus.i_wr_req  = wr;
        bus.i_wr_data = d;
        bus.i_rd_req  = rd;
        wr_acc = wr && (m_count != c_depth);
        rd_acc = rd && (m_count != 0);
        if (wr_acc) sb_q.push_back(d);
        @(posedge clk);
        #1;
        m_count = m_count + (wr_acc ? 1 : 0) - (rd_acc ? 1 : 0);
        chk("rd_valid", 64'(bus.o_rd_valid), 64'(rd_acc));
        if (bus.o_rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("rd_valid_unexpected", 64'(1), 64'(0));
            end else begin
                exp_d = sb_q.pop_front();
                m_last_data = exp_d;
                chk("rd_data", 64'(bus.o_rd_data), 64'(exp_d));
            end
        end else begin
            if (rd_acc && sb_q.size() != 0) void'(sb_q.pop_front());
            chk("rd_data_hold", 64'(bus.o_rd_data), 64'(m_last_data));
        end
        chk("count",     64'(bus.o_count),     64'(m_count));
        chk("empty",     64'(bus.o_empty),     64'(m_count == 0));
        chk("full",      64'(bus.o_full),      64'(m_count == c_depth));
        chk("afull",     64'(bus.o_afull),     64'(m_count >= c_afull));
        chk("aempty",    64'(bus.o_aempty),    64'(m_count <= c_aemp));
        chk("overflow",  64'(bus.o_overflow),  64'(wr && !wr_acc));
        chk("underflow", 64'(bus.o_underflow), 64'(rd && !rd_acc));
    endtask

    // Reset with both requests asserted to exercise reset priority.
    task automatic do_reset();
        rst = 1'b1;
        bus.i_wr_req  = 1'b1;
        bus.i_wr_data = 32'hDEAD_BEEF;
        bus.i_rd_req  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_wr_req = 1'b0;
        bus.i_rd_req = 1'b0;
        sb_q.delete();
        m_count     = 0;
        m_last_data = '0;
        chk("rst_count",     64'(bus.o_count),     64'(0));
        chk("rst_empty",     64'(bus.o_empty),     64'(1));
        chk("rst_aempty",    64'(bus.o_aempty),    64'(1));
        chk("rst_full",      64'(bus.o_full),      64'(0));
        chk("rst_afull",     64'(bus.o_afull),     64'(0));
        chk("rst_rd_valid",  64'(bus.o_rd_valid),  64'(0));
        chk("rst_rd_data",   64'(bus.o_rd_data),   64'(0));
        chk("rst_overflow",  64'(bus.o_overflow),  64'(0));
        chk("rst_underflow", 64'(bus.o_underflow), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Table of hand-derived vectors, applied from an empty FIFO.
        vecs[0] = '{1'b1, 32'h0000_000A, 1'b0, 5'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_000B, 1'b0, 5'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_000C, 1'b1, 5'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 5'd1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_000D, 1'b1, 5'd1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 32'h0000_0000, 1'b1, 5'd0, 1'b0, 1'b0};

        rst = 1'b1;
        bus.i_wr_req  = 1'b0;
        bus.i_wr_data = '0;
        bus.i_rd_req  = 1'b0;
        m_count     = 0;
        m_last_data = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Idle after reset
        cycle(1'b0, 32'h0, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].wr, vecs[i].d, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), 64'(bus.o_count),     64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_ovf", i),   64'(bus.o_overflow),  64'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_udf", i),   64'(bus.o_underflow), 64'(vecs[i].exp_udf));
        end

        // Fill with 0x01..0x10, then one rejected write of 0xFF
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 32'(i), 1'b0);
            if (i == 13) chk("afull_at_13", 64'(bus.o_afull), 64'(0));
            if (i == 14) chk("afull_at_14", 64'(bus.o_afull), 64'(1));
        end
        chk("full_at_16", 64'(bus.o_full), 64'(1));
        cycle(1'b1, 32'h0000_00FF, 1'b0);
        chk("ovf_pulse", 64'(bus.o_overflow), 64'(1));
        chk("count_after_ovf", 64'(bus.o_count), 64'(16));
        cycle(1'b0, 32'h0, 1'b0);
        chk("ovf_one_cycle", 64'(bus.o_overflow), 64'(0));

        // Drain back-to-back, then one extra read
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            chk("drain_order", 64'(bus.o_rd_data), 64'(i));
        end
        chk("empty_after_drain", 64'(bus.o_empty), 64'(1));
        cycle(1'b0, 32'h0, 1'b1);
        chk("udf_pulse", 64'(bus.o_underflow), 64'(1));
        chk("udf_no_valid", 64'(bus.o_rd_valid), 64'(0));

        // Hold at 8 with simultaneous read+write; pointers wrap several times
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 32'h200 + 32'(i), 1'b1);
            chk("steady_count", 64'(bus.o_count), 64'(8));
        end

        // Full with rd+wr: write rejected, read accepted
        for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0);
        cycle(1'b1, 32'hBAD0_0001, 1'b1);
        chk("full_rdwr_count", 64'(bus.o_count), 64'(15));
        chk("full_rdwr_ovf", 64'(bus.o_overflow), 64'(1));

        // Empty with rd+wr: read rejected, write accepted
        for (int i = 0; i < 15; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h0000_0777, 1'b1);
        chk("empty_rdwr_count", 64'(bus.o_count), 64'(1));
        chk("empty_rdwr_udf", 64'(bus.o_underflow), 64'(1));
        cycle(1'b0, 32'h0, 1'b1);

        // Mid-stream reset at count 9
        for (int i = 0; i < 9; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0);
        chk("pre_reset_count", 64'(bus.o_count), 64'(9));
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);

        // Short random traffic after reset
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
